// File: rtl/pc_vectored_if.sv
// Bundle of the PC block's pipeline-facing signals.
// Ports (from the pc_vectored side, modport slave):
//   in : stall, Exception, irq[NIRQ], eret, ie_wr, ie_din, pcin[WIDTH]
//   out: ia[WIDTH], epc[WIDTH], cause[$clog2(NIRQ+1)], in_handler, ie, dfault
// The master modport is the mirror image, used by the pipeline or a bench.
interface pc_vectored_if #(
  parameter int WIDTH = 32,
  parameter int NIRQ  = 4
);
  localparam int CW = $clog2(NIRQ + 1);

  logic             stall;
  logic             Exception;
  logic [NIRQ-1:0]  irq;
  logic             eret;
  logic             ie_wr;
  logic             ie_din;
  logic [WIDTH-1:0] pcin;
  logic [WIDTH-1:0] ia;
  logic [WIDTH-1:0] epc;
  logic [CW-1:0]    cause;
  logic             in_handler;
  logic             ie;
  logic             dfault;

  modport master (
    output stall, Exception, irq, eret, ie_wr, ie_din, pcin,
    input  ia, epc, cause, in_handler, ie, dfault
  );

  modport slave (
    input  stall, Exception, irq, eret, ie_wr, ie_din, pcin,
    output ia, epc, cause, in_handler, ie, dfault
  );
endinterface

// File: rtl/pc_vectored.sv
// Program-counter register with vectored traps.
// Sits between the next-PC mux (bus.pcin) and instruction memory (bus.ia).
// Handles a synchronous exception, NIRQ prioritised level-sensitive IRQs
// (lowest index wins, each with its own vector), EPC/cause capture, a
// HANDLER state left through eret, pipeline stall and a global IRQ enable.
// Ports:
//   clk    in  clock, all state updates on posedge
//   reset  in  synchronous active-high reset, wins over stall
//   bus    pc_vectored_if.slave (see interface header for signal list)
//
// state   | meaning
// RUN     | normal execution, IRQs may be taken when ie=1
// HANDLER | inside a trap handler, IRQs stay pending, eret returns to epc
module pc_vectored #(
  parameter int               WIDTH      = 32,
  parameter int               NIRQ       = 4,
  parameter logic [WIDTH-1:0] RESET_VEC  = 32'h8000_0000,
  parameter logic [WIDTH-1:0] EXC_VEC    = 32'h8000_0004,
  parameter logic [WIDTH-1:0] IRQ_BASE   = 32'h8000_0008,
  parameter logic [WIDTH-1:0] IRQ_STRIDE = 4
) (
  input logic         clk,
  input logic         reset,
  pc_vectored_if.slave bus
);
  localparam int CW = $clog2(NIRQ + 1);

  typedef enum logic {RUN, HANDLER} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ia_q, ia_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [CW-1:0]    cause_q, cause_d;
  logic             ie_q, ie_d;
  logic             dfault_q, dfault_d;

  logic [CW-1:0]    irq_idx;
  logic [WIDTH-1:0] irq_vec;
  logic             irq_take;

  // Priority encoder: scanning downwards leaves the lowest set index.
  always_comb begin
    irq_idx = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (bus.irq[i]) irq_idx = CW'(i);
    end
  end

  // Vector arithmetic wraps naturally at WIDTH bits.
  assign irq_vec  = IRQ_BASE + WIDTH'(irq_idx) * IRQ_STRIDE;
  assign irq_take = ie_q && (state_q == RUN) && (|bus.irq) && !bus.Exception;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      ia_q     <= RESET_VEC;
      epc_q    <= '0;
      cause_q  <= '0;
      ie_q     <= 1'b0;
      dfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ia_q     <= ia_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      ie_q     <= ie_d;
      dfault_q <= dfault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ia_d     = ia_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    ie_d     = ie_q;
    dfault_d = dfault_q;
    if (!bus.stall) begin
      ia_d = bus.pcin;
      if (bus.Exception) begin
        ia_d = EXC_VEC;
        if (state_q == RUN) begin
          epc_d   = ia_q;
          cause_d = '0;
          ie_d    = 1'b0;
          state_d = HANDLER;
        end else begin
          // Nested fault: keep the original return info, flag it sticky.
          dfault_d = 1'b1;
        end
      end else if (irq_take) begin
        ia_d    = irq_vec;
        epc_d   = bus.pcin;
        cause_d = irq_idx + CW'(1);
        ie_d    = 1'b0;
        state_d = HANDLER;
      end else if (bus.eret) begin
        // eret in RUN only falls through to pcin; either way ie_wr is ignored.
        if (state_q == HANDLER) begin
          ia_d    = epc_q;
          ie_d    = 1'b1;
          state_d = RUN;
        end
      end else if (bus.ie_wr) begin
        ie_d = bus.ie_din;
      end
    end
  end

  assign bus.ia         = ia_q;
  assign bus.epc        = epc_q;
  assign bus.cause      = cause_q;
  assign bus.in_handler = (state_q == HANDLER);
  assign bus.ie         = ie_q;
  assign bus.dfault     = dfault_q;
endmodule

// File: tb/tb_pc_vectored.sv
module tb_pc_vectored;
  logic clk;
  logic reset;

  pc_vectored_if #(.WIDTH(32), .NIRQ(4)) bus ();

  pc_vectored dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the architectural state.
  logic [31:0] m_ia, m_epc;
  logic [2:0]  m_cause;
  logic        m_inh, m_ie, m_df;
  bit          cmp_en = 0;

  function automatic logic [31:0] vec_of(int i);
    return 32'h8000_0008 + 32'(i * 4);
  endfunction

  task automatic model_step();
    int first;
    if (reset) begin
      m_ia = 32'h8000_0000; m_epc = 0; m_cause = 0;
      m_inh = 0; m_ie = 0; m_df = 0;
    end else if (!bus.stall) begin
      first = -1;
      for (int i = 3; i >= 0; i--) if (bus.irq[i]) first = i;
      if (bus.Exception) begin
        if (!m_inh) begin
          m_epc = m_ia; m_cause = 0; m_ie = 0; m_inh = 1;
        end else begin
          m_df = 1;
        end
        m_ia = 32'h8000_0004;
      end else if (m_ie && !m_inh && first >= 0) begin
        m_ia = vec_of(first);
        m_epc = bus.pcin;
        m_cause = 3'(first + 1);
        m_ie = 0; m_inh = 1;
      end else if (bus.eret && m_inh) begin
        m_ia = m_epc; m_ie = 1; m_inh = 0;
      end else begin
        if (bus.ie_wr && !bus.eret) m_ie = bus.ie_din;
        m_ia = bus.pcin;
      end
    end
  endtask

  // One posedge: advance model, return at the following negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    cmp_en = 1;
    @(negedge clk);
  endtask

  // Compare process: DUT against model on every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (bus.ia !== m_ia || bus.epc !== m_epc || bus.cause !== m_cause ||
          bus.in_handler !== m_inh || bus.ie !== m_ie || bus.dfault !== m_df) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got ia=%h epc=%h cause=%0d inh=%b ie=%b df=%b, want ia=%h epc=%h cause=%0d inh=%b ie=%b df=%b",
                 $time, bus.ia, bus.epc, bus.cause, bus.in_handler, bus.ie, bus.dfault,
                 m_ia, m_epc, m_cause, m_inh, m_ie, m_df);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.Exception = 0; bus.irq = 0; bus.eret = 0;
    bus.ie_wr = 0; bus.ie_din = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    bus.pcin = 32'hDEAD_BEEF;

    // 1: reset, then sequential fetch
    tick(); tick();
    chk("rst_ia", bus.ia, 32'h8000_0000);
    chk("rst_inh", 32'(bus.in_handler), 0);
    chk("rst_ie", 32'(bus.ie), 0);
    reset = 0; bus.pcin = 32'h8000_0010;
    tick();
    chk("seq_ia", bus.ia, 32'h8000_0010);

    // 2: exception from RUN, then eret
    bus.pcin = 32'h8000_0020; tick();
    bus.Exception = 1; bus.pcin = 32'h8000_0024; tick();
    chk("exc_ia", bus.ia, 32'h8000_0004);
    chk("exc_epc", bus.epc, 32'h8000_0020);
    chk("exc_cause", 32'(bus.cause), 0);
    chk("exc_inh", 32'(bus.in_handler), 1);
    bus.Exception = 0; bus.eret = 1; bus.pcin = 32'h8000_0008; tick();
    chk("eret_ia", bus.ia, 32'h8000_0020);
    chk("eret_ie", 32'(bus.ie), 1);

    // 3: irq[1] wins over irq[3]; held irq does not re-enter
    bus.eret = 0; bus.irq = 4'b1010; bus.pcin = 32'h8000_0044; tick();
    chk("irq_ia", bus.ia, 32'h8000_000C);
    chk("irq_epc", bus.epc, 32'h8000_0044);
    chk("irq_cause", 32'(bus.cause), 2);
    bus.pcin = 32'h8000_0050; tick();
    chk("irq_hold_ia", bus.ia, 32'h8000_0050);
    chk("irq_hold_cause", 32'(bus.cause), 2);
    bus.irq = 0; bus.eret = 1; tick();
    chk("irq_ret_ia", bus.ia, 32'h8000_0044);

    // 4: exception beats irq
    bus.eret = 0; bus.irq = 4'b0001; bus.Exception = 1; bus.pcin = 32'h8000_0060; tick();
    chk("prio_ia", bus.ia, 32'h8000_0004);
    chk("prio_cause", 32'(bus.cause), 0);

    // 5: double fault keeps epc
    bus.irq = 0; bus.Exception = 0; bus.eret = 1; tick();
    bus.eret = 0; bus.pcin = 32'h8000_0100; tick();
    bus.Exception = 1; bus.pcin = 32'h8000_0104; tick();
    chk("df_entry_epc", bus.epc, 32'h8000_0100);
    bus.pcin = 32'h8000_0108; tick();
    chk("df_ia", bus.ia, 32'h8000_0004);
    chk("df_flag", 32'(bus.dfault), 1);
    chk("df_epc", bus.epc, 32'h8000_0100);

    // 6: stall holds everything, reset overrides stall
    bus.stall = 1; bus.irq = 4'b0001; bus.eret = 1; bus.pcin = 32'h1234_5678; tick();
    bus.pcin = 32'h0000_0040; tick();
    chk("stall_ia", bus.ia, 32'h8000_0004);
    chk("stall_epc", bus.epc, 32'h8000_0100);
    chk("stall_inh", 32'(bus.in_handler), 1);
    reset = 1; tick();
    chk("stall_rst_ia", bus.ia, 32'h8000_0000);
    chk("stall_rst_df", 32'(bus.dfault), 0);
    reset = 0; idle_inputs();

    // Enable interrupts, then random traffic against the model.
    bus.ie_wr = 1; bus.ie_din = 1; bus.pcin = 32'h8000_0200; tick();
    chk("iewr_ie", 32'(bus.ie), 1);
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 99) == 0);
      bus.stall     = ($urandom_range(0, 4) == 0);
      bus.Exception = ($urandom_range(0, 11) == 0);
      bus.irq       = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      bus.eret      = ($urandom_range(0, 5) == 0);
      bus.ie_wr     = !bus.eret && ($urandom_range(0, 5) == 0);
      bus.ie_din    = ($urandom_range(0, 3) != 0);
      bus.pcin      = {$urandom()} & 32'hFFFF_FFFC;
      tick();
    end
    reset = 0; idle_inputs();
    tick();
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
